// File: rtl/uo_pad_arbiter.sv
// Arbitrates NREQ 16-bit requesters onto one strobed 17-bit pad word (IDLE -> DRIVE -> GAP).
// Define UO_ARB_ROUNDROBIN_EN for round-robin arbitration; the default build is fixed priority, lowest index wins.
module uo_pad_arbiter #(
   parameter int NREQ        = 4,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      en_i,
   input  logic [NREQ-1:0]           req_valid_i,
   input  logic [NREQ*16-1:0]        req_data_i,
   output logic [NREQ-1:0]           req_ready_o,
   output logic [16:0]               uo_CORE2PAD,
   output logic [$clog2(NREQ)-1:0]   grant_id_o,
   output logic                      busy_o
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [16:0]     r_pad;
   logic [IDW-1:0]  r_grant;
   logic            r_busy;

   logic            w_accept;
   logic            w_found;
   logic [IDW-1:0]  w_win;
   logic [IDW-1:0]  w_cand;
   logic [15:0]     w_data;
   logic [NREQ-1:0] w_ready;
   int              w_base;

`ifdef UO_ARB_ROUNDROBIN_EN
   logic [IDW-1:0]  r_ptr;
`endif

   // Requester index k positions after base, wrapping at NREQ.
   function automatic logic [IDW-1:0] rotate_idx(input int base, input int k);
      int s;
      s = base + k;
      if (s >= NREQ) begin
         s = s - NREQ;
      end else begin
         s = s;
      end
      return IDW'(s);
   endfunction

   // Winner search, winner data mux and one-hot ready (combinational).
   always_comb begin
`ifdef UO_ARB_ROUNDROBIN_EN
      w_base = int'(r_ptr);
`else
      w_base = 0;
`endif
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_cand = rotate_idx(w_base, k);
         if (!w_found && req_valid_i[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end else begin
            w_found = w_found;
         end
      end
      w_data = 16'h0000;
      for (int k = 0; k < NREQ; k++) begin
         if (w_win == IDW'(k)) begin
            w_data = req_data_i[16*k +: 16];
         end else begin
            w_data = w_data;
         end
      end
      w_accept = (r_state == IDLE) && en_i && w_found;
      w_ready  = '0;
      if (w_accept) begin
         w_ready[w_win] = 1'b1;
      end else begin
         w_ready = '0;
      end
   end

   // Pad FSM: load on transfer, hold strobe HOLD_CYCLES cycles, one strobe-low gap cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pad   <= 17'h0_0000;
         r_grant <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_pad   <= {1'b1, w_data};
                  r_grant <= w_win;
                  r_cnt   <= CW'(HOLD_CYCLES);
                  r_busy  <= 1'b1;
                  r_state <= DRIVE;
               end else begin
                  r_state <= IDLE;
               end
            end
            DRIVE: begin
               if (r_cnt == CW'(1)) begin
                  r_pad[16] <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= GAP;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            GAP: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_pad[16] <= 1'b0;
               r_cnt     <= '0;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

`ifdef UO_ARB_ROUNDROBIN_EN
   // Priority pointer moves to the requester after the winner, only on a transfer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : (w_win + IDW'(1));
      end else begin
         r_ptr <= r_ptr;
      end
   end
`endif

   assign req_ready_o = w_ready;
   assign uo_CORE2PAD = r_pad;
   assign grant_id_o  = r_grant;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_uo_pad_arbiter.sv
// Scoreboard bench for uo_pad_arbiter: a cycle model predicts acceptances and words, a monitor checks the pad.
`timescale 1ns/1ps
module tb_uo_pad_arbiter;
   localparam int NREQ = 4;
   localparam int HOLD = 4;
   localparam int IDW  = $clog2(NREQ);

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 en_i;
   logic [NREQ-1:0]      req_valid_i;
   logic [NREQ*16-1:0]   req_data_i;
   logic [NREQ-1:0]      req_ready_o;
   logic [16:0]          uo_CORE2PAD;
   logic [IDW-1:0]       grant_id_o;
   logic                 busy_o;

   uo_pad_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .uo_CORE2PAD (uo_CORE2PAD),
      .grant_id_o  (grant_id_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] data;
      int          id;
   } word_t;

   word_t exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    busy_left = 0;
   int    rr_ptr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // First valid requester scanning upward from ptr, wrapping; -1 if none.
   function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = (ptr + k) % NREQ;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // Reference model: the block is free when no word is in flight; a word occupies HOLD+1 cycles.
   always @(negedge clk_i) begin
      int w;
      logic [NREQ-1:0] exp_ready;
      word_t wd;
      if (!rst_ni) begin
         busy_left = 0;
         rr_ptr    = 0;
         exp_q.delete();
      end else begin
         w = -1;
         exp_ready = '0;
         if (busy_left == 0 && en_i) w = pick(req_valid_i, rr_ptr);
         if (w >= 0) exp_ready[w] = 1'b1;
         check("req_ready", 32'(req_ready_o), 32'(exp_ready));
         check("busy", 32'(busy_o), 32'(busy_left > 0));
         if (w >= 0) begin
            wd.data = req_data_i[16*w +: 16];
            wd.id   = w;
            exp_q.push_back(wd);
            busy_left = HOLD + 1;
`ifdef UO_ARB_ROUNDROBIN_EN
            rr_ptr = (w + 1) % NREQ;
`endif
         end else if (busy_left > 0) begin
            busy_left--;
         end
      end
   end

   logic  prev_strobe = 1'b0;
   int    high_cnt = 0;
   word_t cur;

   // Monitor: each strobe rise pops one expected word; checks hold length and the gap cycle.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_strobe = 1'b0;
         high_cnt    = 0;
      end else begin
         if (uo_CORE2PAD[16] && !prev_strobe) begin
            check("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               check("word_data", 32'(uo_CORE2PAD[15:0]), 32'(cur.data));
               check("grant_id", 32'(grant_id_o), 32'(cur.id));
            end
            high_cnt = 1;
         end else if (uo_CORE2PAD[16]) begin
            high_cnt++;
            check("data_stable", 32'(uo_CORE2PAD[15:0]), 32'(cur.data));
         end else if (prev_strobe) begin
            check("strobe_len", 32'(high_cnt), 32'(HOLD));
            check("gap_data", 32'(uo_CORE2PAD[15:0]), 32'(cur.data));
         end
         prev_strobe = uo_CORE2PAD[16];
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni      = 1'b0;
      en_i        = 1'b0;
      req_valid_i = '0;
      req_data_i  = '0;
      repeat (3) step();
      check("rst_pad", 32'(uo_CORE2PAD), 32'h0);
      check("rst_grant", 32'(grant_id_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      rst_ni = 1'b1;

      // Single word from requester 0.
      en_i = 1'b1;
      req_data_i[15:0] = 16'hA5A5;
      req_valid_i = 4'b0001;
      step();
      req_valid_i = '0;
      check("single_pad", 32'(uo_CORE2PAD), 32'h1A5A5);
      repeat (8) step();

      // Enable gating with requester 2 waiting.
      en_i = 1'b0;
      req_data_i[47:32] = 16'h2222;
      req_valid_i = 4'b0100;
      repeat (10) step();
      en_i = 1'b1;
      step();
      req_valid_i = '0;
      repeat (8) step();

      // All requesters contending.
      req_data_i  = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
      req_valid_i = 4'b1111;
      repeat (36) step();
      req_valid_i = '0;
      repeat (8) step();

      // Requesters 1 and 3 contending.
      req_valid_i = 4'b1010;
      repeat (30) step();
      req_valid_i = '0;
      repeat (8) step();

      // Reset in the second DRIVE cycle of a word from requester 1.
      req_data_i[31:16] = 16'hBEEF;
      req_valid_i = 4'b0010;
      step();
      req_valid_i = '0;
      step();
      #2;
      rst_ni = 1'b0;
      #1;
      check("abort_pad", 32'(uo_CORE2PAD), 32'h0);
      check("abort_busy", 32'(busy_o), 32'h0);
      step();
      rst_ni = 1'b1;
      req_valid_i = 4'b0011;
      step();
      req_valid_i = '0;
      repeat (8) step();

      // Randomized traffic.
      repeat (400) begin
         en_i        = ($urandom_range(0, 7) != 0);
         req_valid_i = NREQ'($urandom);
         req_data_i  = {$urandom, $urandom};
         step();
      end
      req_valid_i = '0;
      en_i = 1'b1;
      repeat (10) step();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
